// File: rtl/tlul_mtimer_if.sv
// tlul_mtimer_if: TL-UL A/D channel bundle between a host and the mtimer device
interface tlul_mtimer_if;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_ready;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic [6:0]  d_user;
  logic        d_error;
  logic        d_ready;
  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );
  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_user, d_error
  );
endinterface

// File: rtl/tlul_mtimer.sv
// tlul_mtimer: TL-UL register slave with prescaled 64-bit mtime/mtimecmp and level timer interrupt
module tlul_mtimer #(
  parameter int PrescaleW = 12,
  parameter int OffsetW   = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  tlul_mtimer_if.slave  tl,
  output logic          intr_timer_o
);
  localparam logic [2:0] PutFull = 3'd0, PutPartial = 3'd1, Get = 3'd4;
  localparam logic [2:0] AccessAck = 3'd0, AccessAckData = 3'd1;
  logic                 en, intr_state, intr_enable, rsp_pending;
  logic [PrescaleW-1:0] prescale, pscnt;
  logic [63:0]          mtime, mtimecmp, mtime_inc;
  logic [2:0]           d_opcode_q;
  logic [1:0]           d_size_q;
  logic [7:0]           d_source_q;
  logic [31:0]          d_data_q, rdata;
  logic                 d_error_q;
  logic [OffsetW-1:0]   off;
  logic                 req, is_get, is_put, err, tick;
  logic [7:0]           wsel;
  assign off       = tl.a_address[OffsetW-1:0];
  assign req       = tl.a_valid & tl.a_ready;
  assign is_get    = tl.a_opcode == Get;
  assign is_put    = tl.a_opcode == PutFull || tl.a_opcode == PutPartial;
  // the xbar routes on bits above the 4 KiB device window, so only [11:0] is decoded
  assign err       = tl.a_address[11:0] >= 12'h20 || off[1:0] != 2'b00 ||
                     (is_put && tl.a_mask != 4'hF) || !(is_get || is_put);
  assign wsel      = (req && is_put && !err) ? 8'b1 << off[4:2] : 8'b0;
  assign tick      = en && pscnt == prescale;
  assign mtime_inc = mtime + 64'(tick);
  always_comb begin
    rdata = '0;
    case (off[4:2])
      3'd0: rdata = {31'b0, en};
      3'd1: rdata = 32'(prescale);
      3'd2: rdata = mtime[31:0];
      3'd3: rdata = mtime[63:32];
      3'd4: rdata = mtimecmp[31:0];
      3'd5: rdata = mtimecmp[63:32];
      3'd6: rdata = {31'b0, intr_state};
      3'd7: rdata = {31'b0, intr_enable};
      default: rdata = '0;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en          <= 1'b0;
      prescale    <= '0;
      pscnt       <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      intr_state  <= 1'b0;
      intr_enable <= 1'b0;
      rsp_pending <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_data_q    <= '0;
      d_error_q   <= 1'b0;
    end else begin
      if (wsel[0]) en <= tl.a_data[0];
      if (wsel[1]) prescale <= tl.a_data[PrescaleW-1:0];
      if (en) pscnt <= tick ? '0 : pscnt + PrescaleW'(1);
      // a software write replaces only its half; the other half keeps the tick and carry
      mtime <= {wsel[3] ? tl.a_data : mtime_inc[63:32], wsel[2] ? tl.a_data : mtime_inc[31:0]};
      if (wsel[4]) mtimecmp[31:0] <= tl.a_data;
      if (wsel[5]) mtimecmp[63:32] <= tl.a_data;
      intr_state <= (mtime >= mtimecmp) | (intr_state & ~(wsel[6] & tl.a_data[0]));
      if (wsel[7]) intr_enable <= tl.a_data[0];
      if (req) begin
        rsp_pending <= 1'b1;
        d_opcode_q  <= is_get ? AccessAckData : AccessAck;
        d_size_q    <= tl.a_size;
        d_source_q  <= tl.a_source;
        d_data_q    <= (is_get && !err) ? rdata : '0;
        d_error_q   <= err;
      end else if (rsp_pending && tl.d_ready) begin
        rsp_pending <= 1'b0;
      end
    end
  end
  assign tl.a_ready   = !rsp_pending;
  assign tl.d_valid   = rsp_pending;
  assign tl.d_opcode  = d_opcode_q;
  assign tl.d_param   = '0;
  assign tl.d_size    = d_size_q;
  assign tl.d_source  = d_source_q;
  assign tl.d_sink    = 1'b0;
  assign tl.d_data    = d_data_q;
  assign tl.d_user    = '0;
  assign tl.d_error   = d_error_q;
  assign intr_timer_o = intr_state & intr_enable;
endmodule

// File: tb/tb_tlul_mtimer.sv
// tb_tlul_mtimer: directed register/timer/handshake checks for tlul_mtimer
module tb_tlul_mtimer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic intr;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [7:0]  src = 8'h01;
  logic [31:0] r_data;
  logic        r_err;
  logic [2:0]  r_op;
  int          r_acc;
  int          e0, k;
  logic [31:0] mt;
  tlul_mtimer_if tl();
  tlul_mtimer dut (.clk_i(clk), .rst_ni(rst_n), .tl(tl), .intr_timer_o(intr));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask);
    int n = 0;
    @(negedge clk);
    tl.a_valid = 1'b1; tl.a_opcode = op; tl.a_address = addr; tl.a_data = data;
    tl.a_mask = mask; tl.a_size = 2'd2; tl.a_source = src; tl.d_ready = 1'b1;
    while (!tl.a_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tl.a_ready) chk("a_ready_timeout", 0, 1);
    r_acc = cyc + 1;
    @(posedge clk);
    #1 tl.a_valid = 1'b0;
    @(negedge clk);
    chk("d_source", tl.d_source, src);
    r_data = tl.d_data; r_err = tl.d_error; r_op = tl.d_opcode;
    src = src + 8'd1;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    xfer(3'd0, addr, data, 4'hF);
  endtask
  task automatic rd(input logic [31:0] addr);
    xfer(3'd4, addr, 32'h0, 4'hF);
  endtask
  initial begin
    tl.a_valid = 1'b0; tl.a_opcode = '0; tl.a_address = '0; tl.a_data = '0;
    tl.a_mask = '0; tl.a_size = '0; tl.a_source = '0; tl.d_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_ready", tl.a_ready, 1);
    chk("rst_d_valid", tl.d_valid, 0);
    chk("rst_intr", intr, 0);
    rst_n = 1'b1;
    rd(32'h10);
    chk("cmp_lo_rst", r_data, 32'hFFFF_FFFF);
    chk("cmp_lo_err", r_err, 0);
    chk("get_opcode", r_op, 3'd1);
    rd(32'h14);
    chk("cmp_hi_rst", r_data, 32'hFFFF_FFFF);
    chk("rst_intr2", intr, 0);
    // prescaled count with interrupt at mtime==10
    wr(32'h04, 32'd3);
    chk("put_opcode", r_op, 3'd0);
    wr(32'h10, 32'd10);
    wr(32'h14, 32'd0);
    wr(32'h1C, 32'd1);
    wr(32'h00, 32'd1);
    e0 = r_acc;
    while (cyc < e0 + 40) @(negedge clk);
    chk("intr_before", intr, 0);
    @(negedge clk);
    chk("intr_rise", intr, 1);
    rd(32'h08);
    chk("mtime_ps3_a", r_data, (r_acc - 1 - e0) / 4);
    repeat (9) @(negedge clk);
    rd(32'h08);
    chk("mtime_ps3_b", r_data, (r_acc - 1 - e0) / 4);
    // stop on a prescale boundary so pscnt is left at 0
    while ((cyc - e0) % 4 != 2) @(negedge clk);
    wr(32'h00, 32'd0);
    chk("stop_align", (r_acc - e0) % 4, 0);
    // 64-bit wrap
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h18, 32'd1);
    rd(32'h18);
    chk("istate_clr", r_data, 0);
    chk("intr_clr", intr, 0);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'd1);
    e0 = r_acc;
    rd(32'h0C);
    k = r_acc - 1 - e0;
    chk("wrap_hi", r_data, k >= 1 ? 32'h0 : 32'hFFFF_FFFF);
    wr(32'h00, 32'd0);
    mt = 32'(r_acc - e0 - 1);
    rd(32'h08);
    chk("wrap_lo", r_data, mt);
    rd(32'h0C);
    chk("wrap_hi2", r_data, 0);
    rd(32'h18);
    chk("wrap_istate", r_data, 1);
    // W1C loses to a live compare, then clears once compare is false
    wr(32'h10, 32'h0);
    wr(32'h14, 32'h0);
    wr(32'h18, 32'd1);
    rd(32'h18);
    chk("w1c_held", r_data, 1);
    chk("w1c_held_intr", intr, 1);
    wr(32'h14, 32'hFFFF_FFFF);
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h18, 32'd1);
    rd(32'h18);
    chk("w1c_clear", r_data, 0);
    chk("w1c_clear_intr", intr, 0);
    // error responses
    wr(32'h04, 32'd5);
    rd(32'h20);
    chk("err_unmapped", r_err, 1);
    chk("err_unmapped_data", r_data, 0);
    xfer(3'd1, 32'h04, 32'd7, 4'h1);
    chk("err_partial", r_err, 1);
    rd(32'h04);
    chk("prescale_kept", r_data, 5);
    chk("prescale_err", r_err, 0);
    rd(32'h06);
    chk("err_misalign", r_err, 1);
    // back-pressure on D channel
    @(negedge clk);
    tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_address = 32'h08; tl.a_mask = 4'hF;
    tl.a_source = 8'h33; tl.d_ready = 1'b0;
    chk("bp_a_ready0", tl.a_ready, 1);
    @(posedge clk);
    #1 tl.a_address = 32'h00; tl.a_source = 8'h44;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_d_valid", tl.d_valid, 1);
      chk("bp_d_data", tl.d_data, mt);
      chk("bp_d_source", tl.d_source, 8'h33);
      chk("bp_a_ready", tl.a_ready, 0);
    end
    tl.d_ready = 1'b1;
    @(negedge clk);
    chk("bp_gap_d_valid", tl.d_valid, 0);
    chk("bp_gap_a_ready", tl.a_ready, 1);
    @(posedge clk);
    #1 tl.a_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", tl.d_valid, 1);
    chk("bp_second_src", tl.d_source, 8'h44);
    chk("bp_second_data", tl.d_data, 0);
    // reset while a response is pending
    @(negedge clk);
    tl.a_valid = 1'b1; tl.a_opcode = 3'd4; tl.a_address = 32'h1C; tl.d_ready = 1'b0;
    @(posedge clk);
    #1 tl.a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_d_valid", tl.d_valid, 0);
    chk("rst_mid_a_ready", tl.a_ready, 1);
    chk("rst_mid_intr", intr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h1C);
    chk("rst_mid_ien", r_data, 0);
    rd(32'h14);
    chk("rst_mid_cmp", r_data, 32'hFFFF_FFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
